dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory bus between two requesters: requester 0 (LSU in the MEM stage, priority) and requester 1 (secondary master, e.g. debug/DMA).
- Serialises transactions through a valid/ready request and response handshake.
- Drops LSU responses on pipeline flush, bounds starvation of requester 1, and converts a memory that never answers into an error response.
- Error responses feed the dmemfault path.

Parameters:
- STARVE_LIMIT, 8: consecutive requester-0 wins while requester 1 waits before requester 1 is forced.
- TIMEOUT, 255: maximum cycles in WAIT before an error response is synthesised.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk, in, 1: clock.
- start, in, 1: synchronous active-low reset.
- flush, in, 1: MEM-stage flush; drops any in-flight requester-0 response.
- rN_valid, in, 1 (N=0,1): request valid.
- rN_write, in, 1: 1 = store, 0 = load.
- rN_addr, in, 32: byte address.
- rN_wdata, in, 32: store data.
- rN_wstrb, in, 4: byte strobes.
- rN_ready, out, 1: request accepted this cycle.
- rN_rsp_valid, out, 1: one-cycle response pulse.
- rN_rdata, out, 32: load data.
- rN_err, out, 1: access fault or timeout.
- m_valid, out, 1: bus request valid.
- m_ready, in, 1: bus accepts request.
- m_write, out, 1: bus store/load.
- m_addr, out, 32: bus address.
- m_wdata, out, 32: bus store data.
- m_wstrb, out, 4: bus byte strobes.
- m_rsp_valid, in, 1: bus response valid.
- m_rdata, in, 32: bus load data.
- m_err, in, 1: bus error.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset (start=0 at posedge):
  - state IDLE; owner, drop, starve_cnt, to_cnt cleared.
  - All outputs 0, including latched m_* fields.
  - Reset mid-transaction abandons it silently; the memory shares start.
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE, grant selection (combinational):
  - r1 wins if r1_valid and (!r0_valid or starve_cnt==STARVE_LIMIT).
  - Otherwise r0 wins if r0_valid and !flush.
  - The winner sees rN_ready=1 in the same cycle.
  - The request is latched, owner is recorded, and the next state is ISSUE.
  - No grant: stay IDLE.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each r0 grant while r1_valid.
  - Clears on any r1 grant.
- ISSUE:
  - m_valid=1 with latched fields, held stable until m_ready.
  - On m_ready the next state is WAIT and to_cnt clears.
  - No timeout in ISSUE, because m_valid must never be retracted.
- WAIT:
  - to_cnt increments each cycle.
  - On m_rsp_valid: next cycle rOwner_rsp_valid=1 for exactly one cycle, with rdata=m_rdata and err=m_err; state IDLE.
  - If to_cnt==TIMEOUT without m_rsp_valid: next cycle rOwner_rsp_valid=1 with err=1 and rdata=0; state DRAIN.
  - m_rsp_valid in the same cycle as to_cnt==TIMEOUT counts as a normal response.
- DRAIN: waits for m_rsp_valid, discards it, returns to IDLE; no requester response.
- Response outputs are registered: one cycle after m_rsp_valid or timeout. rdata holds its value between pulses.
- New grants are legal in the same cycle the response pulse is visible (state is already IDLE).
- Minimum latency: accept at t0, m_valid at t1, with m_ready at t1 and m_rsp_valid at t2, response pulse at t3.
- Flush:
  - If owner==0 and flush is seen in ISSUE or WAIT, drop is set and the transaction still completes on the bus.
  - With drop set, the r0 response pulse is suppressed; drop clears on return to IDLE.
  - Flush has no effect on owner-1 transactions.
  - Flush in an IDLE cycle blocks the r0 grant that cycle.
- Simultaneous r0_valid and r1_valid below the starve limit: r0 wins.
- Simultaneous flush and response with owner==0: the response is suppressed.
- Address and strobes pass through unmodified; alignment is checked upstream.

Decomposition:
- Shared package riscv_defines holds:
  - dmem_arb_state_t enum {IDLE, ISSUE, WAIT, DRAIN}.
  - mem_req_t struct {write, addr, wdata, wstrb}.
  - mem_rsp_t struct {rdata, err}.
  - ARB_OWNER_LSU / ARB_OWNER_EXT constants.
- One sub-module, arb_watchdog: TO_W-bit counter with clear/enable inputs and an expired output (to_cnt==TIMEOUT).

Test Plan:
- Single r0 load, addr=0x100, memory returns 0xDEADBEEF after 1 cycle -> m_valid at t1, r0_rsp_valid at t3, rdata=0xDEADBEEF, err=0; r1 outputs stay 0.
- r0 and r1 both valid continuously, STARVE_LIMIT=8 -> r0 granted 8 times, 9th grant goes to r1, starve_cnt returns to 0, then r0 again.
- r0 store accepted, flush pulsed during WAIT, memory responds 3 cycles later -> m_valid/m_write issued once, no r0_rsp_valid, busy drops, next r0 request granted normally.
- Memory accepts r1 load and never responds, TIMEOUT=255 -> r1_rsp_valid with err=1, rdata=0 at 256 cycles after m_ready; state DRAIN; late m_rsp_valid is discarded; then IDLE.
- m_ready held low 5 cycles -> m_valid and m_addr/m_wdata stable all 5 cycles, no timeout; m_err=1 response -> r0_err=1.
- start=0 asserted during WAIT -> next cycle all outputs 0, busy=0, state IDLE, and no response pulse ever emitted.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared types and constants for the data-memory arbiter and its helpers.
package riscv_defines;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } dmem_arb_state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_rsp_t;

    localparam logic ARB_OWNER_LSU = 1'b0;
    localparam logic ARB_OWNER_EXT = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// Response watchdog: counts cycles while enabled and flags when TIMEOUT is reached.
module arb_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic start,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] to_cnt;

    assign expired = (to_cnt == TO_W'(TIMEOUT));

    // Holding at TIMEOUT keeps the counter from wrapping back to an unexpired value.
    always_ff @(posedge clk) begin
        if (!start) begin
            to_cnt <= '0;
        end else if (clr) begin
            to_cnt <= '0;
        end else if (en && !expired) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory bus arbiter: LSU priority, bounded starvation of the
// secondary master, flush-dropped LSU responses and timeout-to-error conversion.
module dmem_arbiter
    import riscv_defines::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 255,
    parameter int TO_W         = 8
) (
    input  logic        clk,
    input  logic        start,
    input  logic        flush,

    input  logic        r0_valid,
    input  logic        r0_write,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    input  logic [3:0]  r0_wstrb,
    output logic        r0_ready,
    output logic        r0_rsp_valid,
    output logic [31:0] r0_rdata,
    output logic        r0_err,

    input  logic        r1_valid,
    input  logic        r1_write,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    input  logic [3:0]  r1_wstrb,
    output logic        r1_ready,
    output logic        r1_rsp_valid,
    output logic [31:0] r1_rdata,
    output logic        r1_err,

    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_rsp_valid,
    input  logic [31:0] m_rdata,
    input  logic        m_err,

    output logic        busy
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    dmem_arb_state_t state;
    logic            owner;
    logic            drop;
    logic [SC_W-1:0] starve_cnt;
    mem_req_t        req_q;
    mem_req_t        r0_req;
    mem_req_t        r1_req;
    mem_rsp_t        r0_rsp_q;
    mem_rsp_t        r1_rsp_q;
    mem_rsp_t        rsp_next;
    logic            grant0;
    logic            grant1;
    logic            starve_hit;
    logic            expired;
    logic            rsp_fire;

    function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
        return (v == SC_W'(STARVE_LIMIT)) ? v : v + SC_W'(1);
    endfunction

    assign r0_req = '{write: r0_write, addr: r0_addr, wdata: r0_wdata, wstrb: r0_wstrb};
    assign r1_req = '{write: r1_write, addr: r1_addr, wdata: r1_wdata, wstrb: r1_wstrb};

    assign starve_hit = (starve_cnt == SC_W'(STARVE_LIMIT));

    // Grants are gated by start so every output reads 0 while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (start && state == IDLE) begin
            if (r1_valid && (!r0_valid || starve_hit)) begin
                grant1 = 1'b1;
            end else if (r0_valid && !flush) begin
                grant0 = 1'b1;
            end
        end
    end

    assign r0_ready = grant0;
    assign r1_ready = grant1;

    // A real response in the expiry cycle wins over the synthesised error.
    assign rsp_fire = (state == WAIT) && (m_rsp_valid || expired);

    always_comb begin
        if (m_rsp_valid) begin
            rsp_next = '{rdata: m_rdata, err: m_err};
        end else begin
            rsp_next = '{rdata: 32'd0, err: 1'b1};
        end
    end

    arb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .start   (start),
        .clr     (state == ISSUE && m_ready),
        .en      (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!start) begin
            state        <= IDLE;
            owner        <= ARB_OWNER_LSU;
            drop         <= 1'b0;
            starve_cnt   <= '0;
            m_valid      <= 1'b0;
            req_q        <= '0;
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;
            r0_rsp_q     <= '0;
            r1_rsp_q     <= '0;
        end else begin
            r0_rsp_valid <= 1'b0;
            r1_rsp_valid <= 1'b0;

            // A flush arriving with the response still kills an LSU response.
            if (rsp_fire) begin
                if (owner == ARB_OWNER_EXT) begin
                    r1_rsp_valid <= 1'b1;
                    r1_rsp_q     <= rsp_next;
                end else if (!(drop || flush)) begin
                    r0_rsp_valid <= 1'b1;
                    r0_rsp_q     <= rsp_next;
                end
            end

            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        state   <= ISSUE;
                        m_valid <= 1'b1;
                        drop    <= 1'b0;
                        if (grant1) begin
                            owner      <= ARB_OWNER_EXT;
                            req_q      <= r1_req;
                            starve_cnt <= '0;
                        end else begin
                            owner <= ARB_OWNER_LSU;
                            req_q <= r0_req;
                            if (r1_valid) begin
                                starve_cnt <= sat_inc(starve_cnt);
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (owner == ARB_OWNER_LSU && flush) begin
                        drop <= 1'b1;
                    end
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (owner == ARB_OWNER_LSU && flush) begin
                        drop <= 1'b1;
                    end
                    if (m_rsp_valid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end else if (expired) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_rsp_valid) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_write  = req_q.write;
    assign m_addr   = req_q.addr;
    assign m_wdata  = req_q.wdata;
    assign m_wstrb  = req_q.wstrb;

    assign r0_rdata = r0_rsp_q.rdata;
    assign r0_err   = r0_rsp_q.err;
    assign r1_rdata = r1_rsp_q.rdata;
    assign r1_err   = r1_rsp_q.err;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand-written
// sequences for starvation, timeout/drain and reset in mid-transaction.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        start, flush;
    logic        r0_valid, r0_write, r0_ready, r0_rsp_valid, r0_err;
    logic [31:0] r0_addr, r0_wdata, r0_rdata;
    logic [3:0]  r0_wstrb;
    logic        r1_valid, r1_write, r1_ready, r1_rsp_valid, r1_err;
    logic [31:0] r1_addr, r1_wdata, r1_rdata;
    logic [3:0]  r1_wstrb;
    logic        m_valid, m_ready, m_write, m_rsp_valid, m_err, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(8), .TIMEOUT(255), .TO_W(8)) dut (
        .clk(clk), .start(start), .flush(flush),
        .r0_valid(r0_valid), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_wstrb(r0_wstrb), .r0_ready(r0_ready), .r0_rsp_valid(r0_rsp_valid),
        .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_valid(r1_valid), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_wstrb(r1_wstrb), .r1_ready(r1_ready), .r1_rsp_valid(r1_rsp_valid),
        .r1_rdata(r1_rdata), .r1_err(r1_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rsp_valid(m_rsp_valid),
        .m_rdata(m_rdata), .m_err(m_err), .busy(busy)
    );

    typedef struct {
        logic [6:0]  in_bits;  // {r0v, r0w, r1v, flush, m_ready, m_rsp_valid, m_err}
        logic [31:0] a0;
        logic [31:0] mrd;
        logic [5:0]  ef;       // {r0_ready, r1_ready, m_valid, busy, r0_rsp_valid, r1_rsp_valid}
        logic [31:0] erd;
        logic        eerr;
        logic [31:0] ema;
        logic        emw;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] ib, input logic [31:0] a0, input logic [31:0] mrd,
                       input logic [5:0] ef, input logic [31:0] erd, input logic eerr,
                       input logic [31:0] ema, input logic emw);
        vec_t v;
        v.in_bits = ib; v.a0 = a0; v.mrd = mrd; v.ef = ef;
        v.erd = erd; v.eerr = eerr; v.ema = ema; v.emw = emw;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        flush = 0; r0_valid = 0; r0_write = 0; r1_valid = 0;
        m_ready = 0; m_rsp_valid = 0; m_err = 0; m_rdata = 32'h0;
    endtask

    function automatic logic [31:0] all_outs();
        return {23'd0, r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_err, r1_err,
                m_valid, m_write, busy};
    endfunction

    task automatic do_reset(input string tag);
        idle_inputs();
        start = 0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_outs"}, all_outs(), 32'd0);
        check({tag, "_maddr"}, m_addr, 32'd0);
        start = 1;
    endtask

    initial begin
        int who, w, n;
        logic seen;
        start = 0; r0_addr = 32'h100; r0_wdata = 32'hA5A5_0001; r0_wstrb = 4'hF;
        r1_addr = 32'h200; r1_wdata = 32'h5A5A_0002; r1_wstrb = 4'h3; r1_write = 0;
        idle_inputs();

        // single load
        add(7'b1000000, 32'h100, 0, 6'b100000, 0, 0, 0, 0);
        add(7'b0000100, 32'h100, 0, 6'b001100, 0, 0, 32'h100, 0);
        add(7'b0000010, 32'h100, 32'hDEADBEEF, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h100, 0, 6'b000010, 32'hDEADBEEF, 0, 0, 0);
        add(7'b0000000, 32'h100, 0, 6'b000000, 0, 0, 0, 0);
        // store flushed during WAIT, memory answers 3 cycles later
        add(7'b1100000, 32'h104, 0, 6'b100000, 0, 0, 0, 0);
        add(7'b0000100, 32'h104, 0, 6'b001100, 0, 0, 32'h104, 1);
        add(7'b0001000, 32'h104, 0, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h104, 0, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h104, 0, 6'b000100, 0, 0, 0, 0);
        add(7'b0000010, 32'h104, 32'h55, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h104, 0, 6'b000000, 0, 0, 0, 0);
        add(7'b1000000, 32'h100, 0, 6'b100000, 0, 0, 0, 0);
        add(7'b0000100, 32'h100, 0, 6'b001100, 0, 0, 32'h100, 0);
        add(7'b0000010, 32'h100, 32'h12345678, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h100, 0, 6'b000010, 32'h12345678, 0, 0, 0);
        // flush in IDLE blocks the grant; flush coincident with response drops it
        add(7'b1001000, 32'h100, 0, 6'b000000, 0, 0, 0, 0);
        add(7'b1000000, 32'h100, 0, 6'b100000, 0, 0, 0, 0);
        add(7'b0000100, 32'h100, 0, 6'b001100, 0, 0, 32'h100, 0);
        add(7'b0001010, 32'h100, 32'hAAAA, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h100, 0, 6'b000000, 0, 0, 0, 0);
        // owner-1 transaction ignores flush
        add(7'b0010000, 32'h100, 0, 6'b010000, 0, 0, 0, 0);
        add(7'b0001100, 32'h100, 0, 6'b001100, 0, 0, 32'h200, 0);
        add(7'b0001010, 32'h100, 32'hCAFEF00D, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h100, 0, 6'b000001, 32'hCAFEF00D, 0, 0, 0);
        // m_ready low 5 cycles while the requester address changes; error response
        add(7'b1000000, 32'h300, 0, 6'b100000, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(7'b0000000, 32'h400 + k, 0, 6'b001100, 0, 0, 32'h300, 0);
        add(7'b0000100, 32'h444, 0, 6'b001100, 0, 0, 32'h300, 0);
        add(7'b0000011, 32'h444, 32'h0, 6'b000100, 0, 0, 0, 0);
        add(7'b0000000, 32'h444, 0, 6'b000010, 32'h0, 1, 0, 0);

        do_reset("reset");

        foreach (tbl[i]) begin
            {r0_valid, r0_write, r1_valid, flush, m_ready, m_rsp_valid, m_err} = tbl[i].in_bits;
            r0_addr = tbl[i].a0;
            m_rdata = tbl[i].mrd;
            @(negedge clk);
            check($sformatf("v%0d_flags", i),
                  {26'd0, r0_ready, r1_ready, m_valid, busy, r0_rsp_valid, r1_rsp_valid},
                  {26'd0, tbl[i].ef});
            if (tbl[i].ef[3]) begin
                check($sformatf("v%0d_maddr", i), m_addr, tbl[i].ema);
                check($sformatf("v%0d_mwrite", i), {31'd0, m_write}, {31'd0, tbl[i].emw});
            end
            if (tbl[i].ef[1]) begin
                check($sformatf("v%0d_r0rdata", i), r0_rdata, tbl[i].erd);
                check($sformatf("v%0d_r0err", i), {31'd0, r0_err}, {31'd0, tbl[i].eerr});
            end
            if (tbl[i].ef[0]) begin
                check($sformatf("v%0d_r1rdata", i), r1_rdata, tbl[i].erd);
                check($sformatf("v%0d_r1err", i), {31'd0, r1_err}, {31'd0, tbl[i].eerr});
            end
            @(posedge clk);
            #1;
        end

        // timeout: r1 load accepted by memory, no response
        idle_inputs();
        r1_valid = 1;
        #1;
        check("to_grant", {31'd0, r1_ready}, 32'd1);
        @(posedge clk); #1;
        r1_valid = 0; m_ready = 1;
        check("to_mvalid", {31'd0, m_valid}, 32'd1);
        @(posedge clk); #1;
        m_ready = 0;
        n = 0;
        while (!r1_rsp_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("to_latency", n, 256);
        check("to_err", {31'd0, r1_err}, 32'd1);
        check("to_rdata", r1_rdata, 32'd0);
        check("to_busy_drain", {31'd0, busy}, 32'd1);
        r0_valid = 1;
        #1;
        check("drain_no_grant", {30'd0, r0_ready, r1_ready}, 32'd0);
        @(posedge clk); #1;
        r0_valid = 0;
        check("drain_pulse_once", {30'd0, r1_rsp_valid, busy}, 32'd1);
        m_rsp_valid = 1; m_rdata = 32'h99;
        @(posedge clk); #1;
        m_rsp_valid = 0;
        check("drain_discard", {29'd0, r0_rsp_valid, r1_rsp_valid, busy}, 32'd0);

        // starvation bound with both requesters valid continuously
        do_reset("reset2");
        r0_valid = 1; r1_valid = 1; m_ready = 1; m_rsp_valid = 1; m_rdata = 32'h77;
        #1;
        for (int g = 0; g < 18; g++) begin
            w = 0;
            while (!(r0_ready || r1_ready) && w < 8) begin
                @(posedge clk); #1;
                w++;
            end
            who = r1_ready ? 1 : (r0_ready ? 0 : 2);
            check($sformatf("starve_g%0d", g), who, (g == 8 || g == 17) ? 1 : 0);
            @(posedge clk); #1;
        end

        // reset asserted during WAIT
        do_reset("reset3");
        r0_valid = 1;
        @(posedge clk); #1;
        r0_valid = 0; m_ready = 1;
        @(posedge clk); #1;
        m_ready = 0;
        check("rst_in_wait", {31'd0, busy}, 32'd1);
        start = 0; r0_valid = 1;
        @(posedge clk); #1;
        check("rst_outs", all_outs(), 32'd0);
        check("rst_maddr", m_addr, 32'd0);
        check("rst_r0rdata", r0_rdata, 32'd0);
        start = 1; r0_valid = 0; m_rsp_valid = 1; m_rdata = 32'h1234;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            m_rsp_valid = 0;
            seen = seen | r0_rsp_valid | r1_rsp_valid;
        end
        check("rst_no_pulse", {31'd0, seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
